matrix_patch_ctrl: RTL and testbench
====================================

// Module: matrix_patch_ctrl
// PURPOSE
//  Configuration sequencer for the 10-in x 11-out audio routing matrix. Holds a
//  shadow patch (one selector per output), written from the control bus. On
//  commit it applies the patch glitch-free, in step with the audio sample rate.
//  Changed outputs are muted (selector 0) for MUTE_SAMPLES sample ticks, then
//  switched. Drives the matrix sel_out1..sel_out11 inputs directly from sel_flat.
// PARAMETERS
//  N_OUT         11  number of matrix outputs / selector registers
//  N_IN          10  number of matrix inputs; legal selector values 0..N_IN
//  SELW          4   selector width in bits
//  MUTE_SAMPLES  4   sample ticks a changed output is held at selector 0 (0 = no mute)
// PORTS
//  clk          in   1            system clock
//  resetn       in   1            synchronous reset, active low
//  sample_tick  in   1            1-cycle pulse, once per audio sample
//  wr_en        in   1            shadow register write strobe
//  wr_addr      in   4            output index 0..N_OUT-1 (index k drives sel_out(k+1))
//  wr_data      in   SELW         selector value to write
//  commit       in   1            1-cycle pulse: apply shadow patch
//  rd_addr      in   4            readback index
//  rd_data      out  SELW         shadow[rd_addr], registered, 1-cycle latency; 0 if addr>=N_OUT
//  sel_flat     out  N_OUT*SELW   active selectors; out k at bits [k*SELW +: SELW]
//  busy         out  1            high while a commit is in flight
//  mute_mask    out  N_OUT        outputs currently forced to selector 0 by sequencing
// BEHAVIOUR
//  Reset (resetn low at a clk edge): shadow, active, sel_flat, rd_data, busy, mute_mask,
//  pending and counter all 0. All outputs are silent.
//  Writes: on wr_en, shadow[wr_addr] <= wr_data; writes with wr_addr>=N_OUT are ignored;
//   wr_data>N_IN is stored as 0 (illegal source -> silence). Writes are accepted in all states.
//  FSM IDLE -> WAIT_TICK -> MUTE -> APPLY -> IDLE:
//   IDLE: on commit (or pending set), snapshot <= shadow, chg <= per-output (shadow!=active),
//    clear pending. If chg==0, stay in IDLE with busy low. Otherwise go to WAIT_TICK, busy=1.
//   WAIT_TICK: on sample_tick, sel_flat[k] <= 0 for every k in chg; mute_mask <= chg;
//    cnt <= MUTE_SAMPLES. Go to MUTE, or go directly to APPLY if MUTE_SAMPLES==0
//    (no zeroing in that case).
//   MUTE: on sample_tick, cnt <= cnt-1. When cnt==1 and a tick arrives, go to APPLY.
//   APPLY (1 cycle, no tick needed): active[k] <= snapshot[k] and sel_flat[k] <= snapshot[k]
//    for k in chg; mute_mask <= 0; busy <= 0 on exit to IDLE.
//  Unchanged outputs never glitch. Their sel_flat value is constant through the sequence.
//  Latency: zeroed selectors appear the cycle after the first tick following commit. The new
//   selectors appear 2 cycles after the (MUTE_SAMPLES)th tick after that first tick.
//  commit while busy: sets pending (one deep; further commits merge). Pending re-runs the
//   sequence from IDLE using the shadow contents at that time. The in-flight snapshot is
//   unaffected by concurrent writes.
//  commit and sample_tick in the same cycle in IDLE: the tick is not consumed; wait for the next one.
//  Write and commit in the same cycle: the snapshot includes the new write (write-first).
//  resetn mid-sequence: immediate return to the reset state; the snapshot and pending are discarded.
// STRUCTURE
//  Shared package/header: N_OUT, N_IN, SELW defaults; FSM state encodings
//   (ST_IDLE, ST_WAIT_TICK, ST_MUTE, ST_APPLY); SEL_SILENT = 0.
//  Single flat module. No sub-module is needed; the register file is an array of N_OUT x SELW.
//  Counter width is $clog2(MUTE_SAMPLES+1), minimum 1.
// TESTING
//  1 Reset: hold resetn=0 for 3 clks -> sel_flat==0, busy==0, mute_mask==0, rd_data==0.
//  2 Write out0=3 and commit, ticks every 8 clks, MUTE_SAMPLES=4 -> sel_flat[3:0]=0 after
//    tick1; =3 two clks after tick5; busy falls then; other outputs stay 0.
//  3 Active out2=5; write out2=5 and out7=10, commit -> only mute_mask[7] rises; out2
//    stays 5 throughout; out7 ends at 10.
//  4 Write wr_data=12 to out4 -> rd_data==0. Write to addr 13 -> no shadow change.
//    Commit with no diff -> busy never asserts.
//  5 Commit; mid-MUTE write out1=6 and commit again -> first sequence completes unchanged;
//    a second sequence then applies out1=6.
//  6 Assert resetn=0 during MUTE -> next cycle all sel_flat==0, busy==0. A later commit
//    works normally.

Source files
------------

// File: rtl/matrix_patch_ctrl_pkg.sv
// Shared constants and FSM encoding for the audio routing matrix patch sequencer.
package matrix_patch_ctrl_pkg;
    localparam int N_OUT        = 11;
    localparam int N_IN         = 10;
    localparam int SELW         = 4;
    localparam int MUTE_SAMPLES = 4;

    localparam logic [SELW-1:0] SEL_SILENT = '0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TICK = 2'd1,
        ST_MUTE      = 2'd2,
        ST_APPLY     = 2'd3
    } state_t;
endpackage

// File: rtl/matrix_patch_ctrl_if.sv
// Control-bus and matrix-facing signals of the patch sequencer.
interface matrix_patch_ctrl_if #(
    parameter int N_OUT = 11,
    parameter int SELW  = 4
) ();
    logic                  sample_tick;
    logic                  wr_en;
    logic [3:0]            wr_addr;
    logic [SELW-1:0]       wr_data;
    logic                  commit;
    logic [3:0]            rd_addr;
    logic [SELW-1:0]       rd_data;
    logic [N_OUT*SELW-1:0] sel_flat;
    logic                  busy;
    logic [N_OUT-1:0]      mute_mask;

    modport master (
        output sample_tick, wr_en, wr_addr, wr_data, commit, rd_addr,
        input  rd_data, sel_flat, busy, mute_mask
    );

    modport slave (
        input  sample_tick, wr_en, wr_addr, wr_data, commit, rd_addr,
        output rd_data, sel_flat, busy, mute_mask
    );
endinterface

// File: rtl/matrix_patch_ctrl.sv
// Shadow patch register file plus a sample-synchronous mute/apply sequencer
// driving the routing matrix selectors.
//
// state        | meaning
// ST_IDLE      | waiting for commit or a pending re-run
// ST_WAIT_TICK | patch snapshotted, waiting for the first sample tick
// ST_MUTE      | changed outputs held silent, counting sample ticks
// ST_APPLY     | one cycle: load snapshot into changed outputs
module matrix_patch_ctrl #(
    parameter int N_OUT        = matrix_patch_ctrl_pkg::N_OUT,
    parameter int N_IN         = matrix_patch_ctrl_pkg::N_IN,
    parameter int SELW         = matrix_patch_ctrl_pkg::SELW,
    parameter int MUTE_SAMPLES = matrix_patch_ctrl_pkg::MUTE_SAMPLES
) (
    input logic               clk,
    input logic               resetn,
    matrix_patch_ctrl_if.slave bus
);
    import matrix_patch_ctrl_pkg::*;

    localparam int              CNTW     = (MUTE_SAMPLES > 0) ? $clog2(MUTE_SAMPLES + 1) : 1;
    localparam logic [3:0]      ADDR_LIM = 4'(N_OUT);
    localparam logic [SELW-1:0] SEL_MAX  = SELW'(N_IN);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(MUTE_SAMPLES);
    localparam logic [SELW-1:0] SILENT   = SELW'(SEL_SILENT);

    logic [SELW-1:0]  shadow    [N_OUT];
    logic [SELW-1:0]  shadow_nx [N_OUT];
    logic [SELW-1:0]  snapshot  [N_OUT];
    logic [SELW-1:0]  active    [N_OUT];
    logic [SELW-1:0]  sel       [N_OUT];
    logic [N_OUT-1:0] chg;
    logic [N_OUT-1:0] chg_nx;
    logic [N_OUT-1:0] mute_mask;
    logic [CNTW-1:0]  cnt;
    logic [SELW-1:0]  rd_q;
    logic             pending;
    logic             busy;
    logic             launch;
    state_t           state;
    state_t           state_nx;

    // Write-first view of the shadow so a same-cycle commit sees the new write.
    always_comb begin
        for (int k = 0; k < N_OUT; k++) shadow_nx[k] = shadow[k];
        if (bus.wr_en && (bus.wr_addr < ADDR_LIM))
            shadow_nx[bus.wr_addr] = (bus.wr_data > SEL_MAX) ? SILENT : bus.wr_data;
        for (int k = 0; k < N_OUT; k++) chg_nx[k] = (shadow_nx[k] != active[k]);
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        launch   = 1'b0;
        case (state)
            ST_IDLE: begin
                launch = bus.commit || pending;
                if (launch && (chg_nx != '0)) state_nx = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: if (bus.sample_tick) state_nx = (MUTE_SAMPLES == 0) ? ST_APPLY : ST_MUTE;
            ST_MUTE:      if (bus.sample_tick && (cnt == CNTW'(1))) state_nx = ST_APPLY;
            ST_APPLY:     state_nx = ST_IDLE;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < N_OUT; k++) begin
                shadow[k]   <= '0;
                snapshot[k] <= '0;
                active[k]   <= '0;
                sel[k]      <= '0;
            end
            chg       <= '0;
            mute_mask <= '0;
            cnt       <= '0;
            rd_q      <= '0;
            pending   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            for (int k = 0; k < N_OUT; k++) shadow[k] <= shadow_nx[k];
            rd_q <= (bus.rd_addr < ADDR_LIM) ? shadow[bus.rd_addr] : '0;
            busy <= (state_nx != ST_IDLE);

            // Commits outside IDLE merge into a single pending re-run.
            if (launch)          pending <= 1'b0;
            else if (bus.commit) pending <= 1'b1;

            if (launch) begin
                for (int k = 0; k < N_OUT; k++) snapshot[k] <= shadow_nx[k];
                chg <= chg_nx;
            end

            case (state)
                ST_WAIT_TICK: if (bus.sample_tick) begin
                    if (MUTE_SAMPLES > 0) begin
                        for (int k = 0; k < N_OUT; k++) if (chg[k]) sel[k] <= SILENT;
                        mute_mask <= chg;
                    end
                    cnt <= CNT_INIT;
                end
                ST_MUTE: if (bus.sample_tick) cnt <= cnt - CNTW'(1);
                ST_APPLY: begin
                    for (int k = 0; k < N_OUT; k++) begin
                        if (chg[k]) begin
                            active[k] <= snapshot[k];
                            sel[k]    <= snapshot[k];
                        end
                    end
                    mute_mask <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.sel_flat = '0;
        for (int k = 0; k < N_OUT; k++) bus.sel_flat[k*SELW +: SELW] = sel[k];
    end

    assign bus.rd_data   = rd_q;
    assign bus.busy      = busy;
    assign bus.mute_mask = mute_mask;
endmodule

// File: tb/tb_matrix_patch_ctrl.sv
// Self-checking bench for matrix_patch_ctrl: readback vectors from a table,
// patch sequences checked against a model through an expected-result queue.
module tb_matrix_patch_ctrl;
    localparam int NO = 11;
    localparam int SW = 4;
    localparam int FW = NO * SW;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [3:0] data;
        logic [3:0] rd_addr;
        logic [3:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [FW-1:0] flat;
        logic [NO-1:0] mask;
    } exp_t;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    logic [3:0] sh_m  [NO];
    logic [3:0] act_m [NO];
    exp_t       sbq[$];
    logic [3:0] rdq[$];
    vec_t       vec[11];

    matrix_patch_ctrl_if #(.N_OUT(NO), .SELW(SW)) bus ();

    matrix_patch_ctrl dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.sample_tick = 1'b0;
        bus.wr_en       = 1'b0;
        bus.commit      = 1'b0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [3:0] d);
        if (a < 4'd11) sh_m[a] = (d > 4'd10) ? 4'd0 : d;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NO; k++) begin
            sh_m[k]  = '0;
            act_m[k] = '0;
        end
    endtask

    function automatic logic [FW-1:0] flat_of();
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < NO; k++) r[k*SW +: SW] = act_m[k];
        return r;
    endfunction

    function automatic logic [FW-1:0] expand(input logic [NO-1:0] m);
        logic [FW-1:0] r;
        r = '0;
        for (int k = 0; k < NO; k++) if (m[k]) r[k*SW +: SW] = 4'hF;
        return r;
    endfunction

    // A commit whose outcome changes something queues its expected final state.
    task automatic push_commit();
        exp_t e;
        e.mask = '0;
        for (int k = 0; k < NO; k++) if (sh_m[k] !== act_m[k]) e.mask[k] = 1'b1;
        for (int k = 0; k < NO; k++) act_m[k] = sh_m[k];
        e.flat = flat_of();
        if (e.mask != '0) sbq.push_back(e);
    endtask

    task automatic drive_write(input logic [3:0] a, input logic [3:0] d, input logic cmt);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.commit  = cmt;
        model_write(a, d);
        if (cmt) push_commit();
    endtask

    // Ticks every 8 clocks until all queued sequences finish; optional write+commit mid-run.
    task automatic run_seq(input int inj_cyc, input logic [3:0] ia, input logic [3:0] id);
        int            cyc;
        logic          prev_busy;
        logic [NO-1:0] seen;
        logic [FW-1:0] keep_ref;
        logic [FW-1:0] keepm;
        logic          glitch;
        exp_t          e;
        cyc       = 0;
        prev_busy = bus.busy;
        seen      = '0;
        glitch    = 1'b0;
        keep_ref  = bus.sel_flat;
        keepm     = (sbq.size() > 0) ? ~expand(sbq[0].mask) : '1;
        while (sbq.size() > 0 && cyc < 400) begin
            bus.sample_tick = (cyc % 8 == 7);
            if (cyc == inj_cyc) drive_write(ia, id, 1'b1);
            step();
            clear_inputs();
            seen |= bus.mute_mask;
            if ((bus.sel_flat & keepm) !== (keep_ref & keepm)) glitch = 1'b1;
            if (prev_busy && !bus.busy) begin
                e = sbq.pop_front();
                check("seq_sel_flat", bus.sel_flat, e.flat);
                check("seq_mute_mask", seen, e.mask);
                check("seq_unchanged_stable", glitch, 1'b0);
                seen     = '0;
                glitch   = 1'b0;
                keep_ref = bus.sel_flat;
                keepm    = (sbq.size() > 0) ? ~expand(sbq[0].mask) : '1;
            end
            prev_busy = bus.busy;
            cyc++;
        end
        check("seq_completed_in_budget", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        logic busy_seen;
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        clear_inputs();
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        model_reset();

        vec[0]  = '{we: 1'b1, addr: 4'd4,  data: 4'd12, rd_addr: 4'd4,  exp_rd: 4'd0};
        vec[1]  = '{we: 1'b1, addr: 4'd13, data: 4'd5,  rd_addr: 4'd13, exp_rd: 4'd0};
        vec[2]  = '{we: 1'b1, addr: 4'd9,  data: 4'd10, rd_addr: 4'd9,  exp_rd: 4'd10};
        vec[3]  = '{we: 1'b1, addr: 4'd9,  data: 4'd11, rd_addr: 4'd9,  exp_rd: 4'd0};
        vec[4]  = '{we: 1'b1, addr: 4'd3,  data: 4'd15, rd_addr: 4'd3,  exp_rd: 4'd0};
        vec[5]  = '{we: 1'b0, addr: 4'd0,  data: 4'd0,  rd_addr: 4'd0,  exp_rd: 4'd3};
        vec[6]  = '{we: 1'b0, addr: 4'd0,  data: 4'd0,  rd_addr: 4'd7,  exp_rd: 4'd10};
        vec[7]  = '{we: 1'b0, addr: 4'd0,  data: 4'd0,  rd_addr: 4'd2,  exp_rd: 4'd5};
        vec[8]  = '{we: 1'b1, addr: 4'd10, data: 4'd1,  rd_addr: 4'd10, exp_rd: 4'd1};
        vec[9]  = '{we: 1'b1, addr: 4'd15, data: 4'd9,  rd_addr: 4'd15, exp_rd: 4'd0};
        vec[10] = '{we: 1'b1, addr: 4'd10, data: 4'd0,  rd_addr: 4'd10, exp_rd: 4'd0};

        // Reset state
        repeat (3) step();
        check("rst_sel_flat", bus.sel_flat, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mute_mask", bus.mute_mask, 0);
        check("rst_rd_data", bus.rd_data, 0);
        resetn = 1'b1;
        step();

        // Exact latency of a single-output patch
        bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 4'd3; bus.commit = 1'b1;
        model_write(4'd0, 4'd3);
        for (int k = 0; k < NO; k++) act_m[k] = sh_m[k];
        step();
        clear_inputs();
        check("t2_busy_rise", bus.busy, 1);
        check("t2_sel_before_tick", bus.sel_flat, 0);
        for (int t = 1; t <= 5; t++) begin
            repeat (7) step();
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
            if (t == 1) check("t2_mask_after_tick1", bus.mute_mask, 11'h001);
        end
        check("t2_sel_at_tick5", bus.sel_flat, 0);
        check("t2_busy_at_tick5", bus.busy, 1);
        step();
        check("t2_sel_applied", bus.sel_flat, flat_of());
        check("t2_busy_fall", bus.busy, 0);
        check("t2_mask_clear", bus.mute_mask, 0);

        // Make out2=5 active
        drive_write(4'd2, 4'd5, 1'b1);
        step();
        clear_inputs();
        run_seq(-1, 4'd0, 4'd0);

        // Rewrite out2 unchanged, out7 new: only out7 sequences
        drive_write(4'd2, 4'd5, 1'b0);
        step();
        drive_write(4'd7, 4'd10, 1'b1);
        step();
        clear_inputs();
        run_seq(-1, 4'd0, 4'd0);

        // Readback vectors, illegal values and out-of-range addresses
        for (int i = 0; i < 11; i++) begin
            bus.wr_en   = vec[i].we;
            bus.wr_addr = vec[i].addr;
            bus.wr_data = vec[i].data;
            if (vec[i].we) model_write(vec[i].addr, vec[i].data);
            step();
            bus.wr_en   = 1'b0;
            bus.rd_addr = vec[i].rd_addr;
            rdq.push_back(vec[i].exp_rd);
            step();
            check($sformatf("vec%0d_rd_data", i), bus.rd_data, rdq.pop_front());
        end
        for (int a = 0; a < NO; a++) begin
            bus.rd_addr = 4'(a);
            rdq.push_back(sh_m[a]);
            step();
            check($sformatf("shadow%0d_rd_data", a), bus.rd_data, rdq.pop_front());
        end

        // Commit with no difference never asserts busy
        bus.commit = 1'b1;
        push_commit();
        step();
        clear_inputs();
        busy_seen = bus.busy;
        for (int c = 0; c < 20; c++) begin
            bus.sample_tick = (c % 8 == 3);
            step();
            busy_seen |= bus.busy;
        end
        clear_inputs();
        check("t4_nodiff_busy", busy_seen, 0);
        check("t4_nodiff_queue", sbq.size(), 0);

        // Commit while busy: first sequence untouched, pending one applies later
        drive_write(4'd3, 4'd9, 1'b1);
        step();
        clear_inputs();
        run_seq(20, 4'd1, 4'd6);

        // Reset in the middle of MUTE
        drive_write(4'd5, 4'd7, 1'b1);
        step();
        clear_inputs();
        for (int t = 0; t < 2; t++) begin
            repeat (7) step();
            bus.sample_tick = 1'b1;
            step();
            bus.sample_tick = 1'b0;
        end
        check("t6_mask_in_mute", bus.mute_mask, 11'h020);
        resetn = 1'b0;
        sbq.delete();
        model_reset();
        step();
        check("t6_rst_sel_flat", bus.sel_flat, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_mask", bus.mute_mask, 0);
        resetn = 1'b1;
        step();
        bus.rd_addr = 4'd5;
        rdq.push_back(4'd0);
        step();
        check("t6_shadow_cleared", bus.rd_data, rdq.pop_front());

        // Commit coinciding with a tick does not consume that tick
        drive_write(4'd6, 4'd4, 1'b1);
        bus.sample_tick = 1'b1;
        step();
        clear_inputs();
        check("t6_tick_not_consumed", bus.mute_mask, 0);
        check("t6_busy_after_commit", bus.busy, 1);
        run_seq(-1, 4'd0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
